// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin registered multiplexer.
package mux_pkg;

    localparam logic        MODE_RR     = 1'b0;
    localparam logic        MODE_MANUAL = 1'b1;
    localparam int unsigned CNT_W       = 16;

    // Ceiling log2; callers apply their own minimum width.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_nbit_rr_arbiter.sv
// Combinational rotate-priority search: first requester at or after ptr, wrapping at M.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned M    = 4,
    localparam int unsigned SELW = (clog2(M) < 1) ? 1 : clog2(M)
) (
    input  logic [M-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int unsigned     pos;
        logic [SELW-1:0] idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = int'(M) - 1; k >= 0; k--) begin
            pos = (32'(ptr) + 32'(k)) % M;
            idx = SELW'(pos);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_nbit.sv
// M-input, N-bit registered mux with per-channel valid/ready, round-robin or manual select.
// Optional per-channel saturating grant counters with MUX_RR_STATS_EN.
module mux_rr_nbit
    import mux_pkg::*;
#(
    parameter  int unsigned N    = 3,
    parameter  int unsigned M    = 4,
    localparam int unsigned SELW = (clog2(M) < 1) ? 1 : clog2(M)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [M*N-1:0]    in_data,
    input  logic [M-1:0]      in_valid,
    output logic [M-1:0]      in_ready,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    output logic [N-1:0]      out_data,
    output logic [SELW-1:0]   out_sel,
    output logic              out_valid,
`ifdef MUX_RR_STATS_EN
    output logic [M*CNT_W-1:0] grant_cnt,
`endif
    input  logic              out_ready
);

    logic [SELW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    data_q, data_d;
    logic [SELW-1:0] osel_q, osel_d;
    logic            valid_q, valid_d;

    logic [SELW-1:0] arb_idx;
    logic            arb_any;
    logic [SELW-1:0] grant_idx;
    logic            grant_any;
    logic            load_en;
    logic            xfer;

    rr_arbiter #(.M(M)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Grant selection, handshake and next-state for the output stage and pointer.
    always_comb begin
        grant_idx = arb_idx;
        grant_any = arb_any;
        ptr_d     = ptr_q;
        data_d    = data_q;
        osel_d    = osel_q;
        valid_d   = valid_q;
        in_ready  = '0;

        if (mode == MODE_MANUAL) begin
            grant_idx = sel;
            grant_any = (32'(sel) < M) && in_valid[sel];
        end

        load_en = !valid_q || out_ready;
        xfer    = grant_any && load_en && !reset;

        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
            data_d  = in_data[32'(grant_idx)*N +: N];
            osel_d  = grant_idx;
            valid_d = 1'b1;
            if (mode == MODE_RR) begin
                ptr_d = (32'(grant_idx) == M - 1) ? '0 : grant_idx + SELW'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            data_q  <= '0;
            osel_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            osel_q  <= osel_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = osel_q;
    assign out_valid = valid_q;

`ifdef MUX_RR_STATS_EN
    logic [CNT_W-1:0] cnt_q [M];
    logic [CNT_W-1:0] cnt_d [M];

    // Saturating per-channel transfer counters.
    always_comb begin
        for (int i = 0; i < int'(M); i++) begin
            cnt_d[i] = cnt_q[i];
            if (xfer && (grant_idx == SELW'(i)) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(M); i++) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < int'(M); gi++) begin : g_cnt
        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_mux_rr_nbit.sv
// Self-checking bench for mux_rr_nbit: directed scenarios plus randomized traffic vs a queue-free behavioural model.
module tb_mux_rr_nbit;

    localparam int N    = 3;
    localparam int M    = 4;
    localparam int SELW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [M*N-1:0]    in_data;
    logic [M-1:0]      in_valid;
    logic [M-1:0]      in_ready;
    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N-1:0]      out_data;
    logic [SELW-1:0]   out_sel;
    logic              out_valid;
    logic              out_ready;
`ifdef MUX_RR_STATS_EN
    logic [M*16-1:0]   grant_cnt;
    int                m_cnt [M];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural reference state
    int m_ptr, m_valid, m_data, m_sel;

    always #5 clk = ~clk;

    mux_rr_nbit #(.N(N), .M(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
`ifdef MUX_RR_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int word(input int ch);
        logic [M*N-1:0] d;
        d = in_data;
        return int'(d[ch*N +: N]);
    endfunction

    // One cycle: check in_ready at the low phase, advance the model, check outputs after the edge.
    task automatic step();
        int g;
        int exp_rdy;
        bit any;
        @(negedge clk);
        any = 0;
        g = 0;
        if (mode == 1'b0) begin
            for (int k = 0; k < M; k++) begin
                if (!any && in_valid[(m_ptr + k) % M]) begin
                    any = 1;
                    g = (m_ptr + k) % M;
                end
            end
        end else if (int'(sel) < M && in_valid[sel]) begin
            any = 1;
            g = int'(sel);
        end
        if (reset || !(m_valid == 0 || out_ready)) any = 0;
        exp_rdy = any ? (1 << g) : 0;
        chk("in_ready", int'(in_ready), exp_rdy);

        if (reset) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
`ifdef MUX_RR_STATS_EN
            for (int i = 0; i < M; i++) m_cnt[i] = 0;
`endif
        end else if (any) begin
            m_valid = 1; m_data = word(g); m_sel = g;
            if (mode == 1'b0) m_ptr = (g + 1) % M;
`ifdef MUX_RR_STATS_EN
            if (m_cnt[g] < 65535) m_cnt[g]++;
`endif
        end else if (out_ready) begin
            m_valid = 0;
        end

        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), m_valid);
        chk("out_data",  int'(out_data),  m_data);
        chk("out_sel",   int'(out_sel),   m_sel);
`ifdef MUX_RR_STATS_EN
        for (int i = 0; i < M; i++) chk("grant_cnt", int'(grant_cnt[i*16 +: 16]), m_cnt[i]);
`endif
    endtask

    task automatic set_data_plus1();
        for (int i = 0; i < M; i++) in_data[i*N +: N] = N'(i + 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
        reset     = 1'b1;
        in_data   = M*N'($urandom);
        in_valid  = M'($urandom);
        mode      = 1'($urandom);
        sel       = SELW'($urandom);
        out_ready = 1'($urandom);

        // Reset with random inputs
        step();
        step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data),  0);
        chk("rst_out_sel",   int'(out_sel),   0);
        chk("rst_in_ready",  int'(in_ready),  0);

        // Round-robin with all channels valid: 0,1,2,3,0,...
        reset = 1'b0; mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        set_data_plus1();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_seq_sel",  int'(out_sel),  k % 4);
            chk("rr_seq_data", int'(out_data), (k % 4) + 1);
            chk("rr_seq_vld",  int'(out_valid), 1);
        end

        // Sparse requesters 1010 from ptr 0, then ch1 alone
        do_reset();
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("sparse_sel", int'(out_sel), (k % 2 == 0) ? 1 : 3);
        end
        in_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ch1_only_sel", int'(out_sel), 1);
        end

        // Backpressure holds word 5
        mode = 1'b1; sel = 2'd0; in_valid = 4'b1111;
        in_data[0 +: N] = 3'd5;
        step();
        chk("bp_load", int'(out_data), 5);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_data", int'(out_data), 5);
            chk("bp_hold_vld",  int'(out_valid), 1);
            chk("bp_no_ready",  int'(in_ready), 0);
        end
        out_ready = 1'b1; sel = 2'd1; in_data[N +: N] = 3'd2;
        step();
        chk("bp_release_data", int'(out_data), 2);
        chk("bp_release_sel",  int'(out_sel), 1);

        // Manual select channel 2, then channel 2 idle
        sel = 2'd2;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("man_sel", int'(out_sel), 2);
        end
        in_valid = 4'b1011;
        step();
        chk("man_drain_vld", int'(out_valid), 0);
        chk("man_drain_sel", int'(out_sel), 2);

        // Back to round-robin: pointer untouched by manual mode (still 2 from ch1 grant)
        mode = 1'b0; in_valid = 4'b1111;
        step();
        chk("ptr_held_sel", int'(out_sel), 2);

        // Reset mid-stream drops the pending word
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("midrst_vld", int'(out_valid), 0);
        reset = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            in_data   = M*N'($urandom);
            in_valid  = M'($urandom);
            mode      = ($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1;
            sel       = SELW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;

`ifdef MUX_RR_STATS_EN
        // Saturation of channel 0 counter
        do_reset();
        mode = 1'b0; in_valid = 4'b0001; out_ready = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            @(posedge clk);
            if (in_ready[0] && m_cnt[0] < 65535) m_cnt[0]++;
        end
        m_valid = 1; m_data = word(0); m_sel = 0; m_ptr = 1;
        step();
        chk("sat_ch0", int'(grant_cnt[15:0]), 65535);
        chk("sat_ch1", int'(grant_cnt[31:16]), 0);
        reset = 1'b1;
        step();
        chk("cnt_clear", int'(grant_cnt[15:0]), 0);
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
